// File: rtl/keypad_code_entry.sv
// Keypad front end for the digital safe: collects BCD digits, submits on ENTER, clears on CLEAR/timeout.
// Optional backspace key (0xC) enabled by defining KEYPAD_BACKSPACE_EN.
module keypad_code_entry #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [31:0] entered_code,
    output logic        code_valid,
    output logic [3:0]  digit_count,
    output logic        entry_active,
    output logic        timeout_flag
);

    localparam int unsigned CODE_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TMR_W  = 20;
    localparam int unsigned TMR_XW = TMR_W + 1;

    localparam logic [3:0]       KEY_BKSP   = 4'hC;
    localparam logic [3:0]       KEY_ENTER  = 4'hE;
    localparam logic [3:0]       KEY_CLEAR  = 4'hF;
    localparam logic [CNT_W-1:0] MAX_DIGITS = CNT_W'(NUM_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_SUBMIT
    } state_e;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic                active_q, active_d;
    logic                tflag_q, tflag_d;
    logic                key_hit;
    logic                is_digit;
    logic                tmr_expire;

    assign is_digit   = (key_code <= 4'd9);
    // Expiry fires on the cycle whose increment would reach TIMEOUT_CYCLES-1.
    assign tmr_expire = ({1'b0, tmr_q} + TMR_XW'(2)) >= {1'b0, TIMEOUT_CYCLES};

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        count_d  = count_q;
        tmr_d    = '0;
        code_d   = code_q;
        tflag_d  = 1'b0;
        key_hit  = 1'b0;
        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (key_valid) begin
                    if (is_digit) begin
                        key_hit = 1'b1;
                        if (count_q < MAX_DIGITS) begin
                            buf_d   = {buf_q[CODE_W-5:0], key_code};
                            count_d = count_q + CNT_W'(1);
                            state_d = S_ENTRY;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (count_q != '0) begin
                            key_hit = 1'b1;
                            code_d  = buf_q;
                            buf_d   = '0;
                            count_d = '0;
                            state_d = S_SUBMIT;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        key_hit = 1'b1;
                        buf_d   = '0;
                        count_d = '0;
                        state_d = S_IDLE;
                    end
`ifdef KEYPAD_BACKSPACE_EN
                    else if (key_code == KEY_BKSP && state_q == S_ENTRY) begin
                        key_hit = 1'b1;
                        buf_d   = {4'h0, buf_q[CODE_W-1:4]};
                        if (count_q != '0) begin
                            count_d = count_q - CNT_W'(1);
                        end
                        if (count_q <= CNT_W'(1)) begin
                            state_d = S_IDLE;
                        end
                    end
`endif
                end
                // Idle time only accumulates in ENTRY; an accepted key always wins over expiry.
                if (!key_hit && state_q == S_ENTRY) begin
                    if (tmr_expire) begin
                        buf_d   = '0;
                        count_d = '0;
                        state_d = S_IDLE;
                        tflag_d = 1'b1;
                    end else begin
                        tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
                    end
                end
            end
            S_SUBMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        valid_d  = (state_d == S_SUBMIT);
        active_d = (state_d == S_ENTRY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            count_q  <= '0;
            tmr_q    <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            tflag_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            count_q  <= count_d;
            tmr_q    <= tmr_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            tflag_q  <= tflag_d;
        end
    end

    assign entered_code = code_q;
    assign code_valid   = valid_q;
    assign digit_count  = count_q;
    assign entry_active = active_q;
    assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Self-checking bench for keypad_code_entry: queue-based reference model, directed scenarios, random key streams.
module tb_keypad_code_entry;

    localparam int unsigned T_CYC = 16;
`ifdef KEYPAD_BACKSPACE_EN
    localparam bit BK = 1'b1;
`else
    localparam bit BK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [31:0] entered_code;
    logic        code_valid;
    logic [3:0]  digit_count;
    logic        entry_active;
    logic        timeout_flag;

    keypad_code_entry #(
        .NUM_DIGITS    (8),
        .TIMEOUT_CYCLES(20'd16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .entered_code (entered_code),
        .code_valid   (code_valid),
        .digit_count  (digit_count),
        .entry_active (entry_active),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: digit queue, entry flag, timestamp of last accepted key.
    logic [3:0]  m_q[$];
    bit          m_entry  = 1'b0;
    bit          m_submit = 1'b0;
    logic [31:0] m_code   = '0;
    bit          m_valid  = 1'b0;
    bit          m_tflag  = 1'b0;
    int          m_last   = 0;
    int          cyc      = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kc, input logic r);
        bit accepted;
        accepted = 1'b0;
        m_valid  = 1'b0;
        m_tflag  = 1'b0;
        if (r) begin
            m_q.delete();
            m_entry  = 1'b0;
            m_submit = 1'b0;
            m_code   = '0;
        end else if (m_submit) begin
            m_submit = 1'b0;
        end else begin
            if (kv) begin
                if (kc <= 4'd9) begin
                    accepted = 1'b1;
                    if (m_q.size() < 8) begin
                        m_q.push_back(kc);
                        m_entry = 1'b1;
                    end
                end else if (kc == 4'hE && m_q.size() > 0) begin
                    accepted = 1'b1;
                    m_code = '0;
                    foreach (m_q[i]) m_code = (m_code << 4) | 32'(m_q[i]);
                    m_q.delete();
                    m_entry  = 1'b0;
                    m_submit = 1'b1;
                    m_valid  = 1'b1;
                end else if (kc == 4'hF) begin
                    accepted = 1'b1;
                    m_q.delete();
                    m_entry = 1'b0;
                end else if (kc == 4'hC && BK && m_entry) begin
                    accepted = 1'b1;
                    void'(m_q.pop_back());
                    if (m_q.size() == 0) m_entry = 1'b0;
                end
            end
            if (accepted) begin
                m_last = cyc;
            end else if (m_entry && (cyc - m_last) >= int'(T_CYC) - 1) begin
                m_q.delete();
                m_entry = 1'b0;
                m_tflag = 1'b1;
            end
        end
        cyc++;
    endtask

    // Single compare process: every cycle, outputs versus model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("entered_code", entered_code, m_code);
            cmp("code_valid", 32'(code_valid), 32'(m_valid));
            cmp("digit_count", 32'(digit_count), 32'(m_q.size()));
            cmp("entry_active", 32'(entry_active), 32'(m_entry));
            cmp("timeout_flag", 32'(timeout_flag), 32'(m_tflag));
        end
    end

    task automatic drive(input logic kv, input logic [3:0] kc, input logic r);
        key_valid = kv;
        key_code  = kc;
        rst       = r;
        @(posedge clk);
        model_step(kv, kc, r);
        @(negedge clk);
    endtask

    task automatic key(input logic [3:0] kc);
        drive(1'b1, kc, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0);
    endtask

    logic [31:0] bk_exp;

    initial begin
        drive(1'b0, 4'h0, 1'b1);
        chk_en = 1'b1;
        drive(1'b0, 4'h0, 1'b1);
        cmp("pin_reset_code", entered_code, 32'h0);
        cmp("pin_reset_count", 32'(digit_count), 32'd0);

        // Eight-digit entry
        for (int d = 1; d <= 8; d++) key(4'(d));
        cmp("pin_count8", 32'(digit_count), 32'd8);
        key(4'hE);
        cmp("pin_valid8", 32'(code_valid), 32'd1);
        cmp("pin_code8", entered_code, 32'h12345678);
        idle(1);
        cmp("pin_valid8_low", 32'(code_valid), 32'd0);
        cmp("pin_count8_clr", 32'(digit_count), 32'd0);

        // Short code and empty ENTER
        key(4'h9); key(4'h9); key(4'hE);
        cmp("pin_code99", entered_code, 32'h00000099);
        idle(1);
        key(4'hE);
        cmp("pin_empty_enter", 32'(code_valid), 32'd0);
        cmp("pin_code99_hold", entered_code, 32'h00000099);

        // Overflow, then clear
        for (int d = 1; d <= 9; d++) key(4'(d));
        key(4'hE);
        cmp("pin_overflow", entered_code, 32'h12345678);
        idle(1);
        key(4'h4); key(4'hF); key(4'hE);
        cmp("pin_clear_enter", 32'(code_valid), 32'd0);

        // Timeout and key on the expiry cycle
        key(4'h5);
        idle(14);
        cmp("pin_tmo_early", 32'(timeout_flag), 32'd0);
        idle(1);
        cmp("pin_tmo_flag", 32'(timeout_flag), 32'd1);
        cmp("pin_tmo_count", 32'(digit_count), 32'd0);
        idle(1);
        key(4'h5);
        idle(14);
        key(4'h6);
        cmp("pin_tmo_keywins", 32'(timeout_flag), 32'd0);
        cmp("pin_tmo_keycount", 32'(digit_count), 32'd2);
        key(4'hF);

        // Reset mid-entry
        key(4'h7); key(4'h7);
        drive(1'b0, 4'h0, 1'b1);
        key(4'hE);
        cmp("pin_rst_valid", 32'(code_valid), 32'd0);
        cmp("pin_rst_code", entered_code, 32'h0);

        // Backspace sequence
        key(4'h1); key(4'h2); key(4'h3); key(4'hC); key(4'h4); key(4'hE);
        bk_exp = BK ? 32'h00000124 : 32'h00001234;
        cmp("pin_backspace", entered_code, bk_exp);
        idle(1);

        // Random key streams with occasional long gaps and resets
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] kc;
            if ($urandom_range(0, 99) < 65) kc = 4'($urandom_range(0, 9));
            else kc = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 299) == 0) drive(1'b0, 4'h0, 1'b1);
            else if ($urandom_range(0, 99) < 70) drive(1'b1, kc, 1'b0);
            else drive(1'b0, 4'h0, 1'b0);
            if ($urandom_range(0, 19) == 0) idle(int'($urandom_range(10, 20)));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_code_entry.md
# keypad_code_entry

Upstream front end of the digital safe. It collects keypad presses (one 4-bit key code per strobe) into a packed 8-digit BCD code. On ENTER it presents the code on `entered_code` with a one-cycle `code_valid` pulse, which the safe's comparison logic consumes. It also handles clear, inactivity timeout and digit-overflow, so the safe only ever sees complete, deliberate submissions.

## Interface
Parameters:
- `NUM_DIGITS`, 8: maximum digits held; code width is 4*NUM_DIGITS, fixed at 32 for this design.
- `TIMEOUT_CYCLES`, 20'd1_000_000: idle cycles in ENTRY before the partial code is discarded.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `key_valid`  in  1  one-cycle strobe; `key_code` is sampled when high.
- `key_code`  in  4  0x0–0x9 digit, 0xC backspace, 0xE ENTER, 0xF CLEAR; 0xA, 0xB, 0xD ignored.
- `entered_code`  out  32  last submitted code, packed BCD, most recent digit in [3:0].
- `code_valid`  out  1  one-cycle pulse; `entered_code` is new this cycle.
- `digit_count`  out  4  digits currently buffered, 0..NUM_DIGITS.
- `entry_active`  out  1  high while in ENTRY.
- `timeout_flag`  out  1  one-cycle pulse when a partial entry is discarded by timeout.

## Operation
- States are IDLE, ENTRY and SUBMIT.
- **Reset:** state IDLE; buffer=0; `digit_count`=0; `entered_code`=0; `code_valid`=0; `entry_active`=0; `timeout_flag`=0; timeout counter=0. Reset mid-entry discards everything, with no pulse.
- **Digit key, IDLE or ENTRY, count<NUM_DIGITS:**
  - buffer <= {buffer[27:0], key_code}; count++.
  - State goes to ENTRY; timeout counter cleared.
- **Digit key, count==NUM_DIGITS:** digit dropped; buffer and count unchanged; timeout counter still cleared.
- **ENTER, count≥1:**
  - `entered_code` <= buffer (right-aligned, leading zero nibbles); state goes to SUBMIT.
  - Buffer and count cleared.
- **ENTER, count==0:** ignored; state unchanged.
- **CLEAR:** buffer=0, count=0, state goes to IDLE; no `code_valid`, no `timeout_flag`.
- **SUBMIT:** lasts exactly one cycle with `code_valid`=1, then IDLE. A `key_valid` arriving in the SUBMIT cycle is ignored.
- **Timeout:**
  - In ENTRY the counter increments every cycle without an accepted key.
  - When it reaches TIMEOUT_CYCLES-1: buffer/count cleared, state goes to IDLE, `timeout_flag`=1 for one cycle.
- **Simultaneous key_valid and timeout expiry:** the key wins; it is processed and the counter is cleared.
- **Holding:** `entered_code` holds its value until the next submission; it is never cleared except by `rst`.
- **Counter width:** the timeout counter is 20 bits and saturates, with no wrap.

## Timing
- Key to buffer update: 1 cycle (`digit_count` reflects the key the cycle after the strobe).
- ENTER strobe at cycle N: `entered_code` and `code_valid` valid at N+1; `code_valid` low at N+2.
- Back-to-back strobes on consecutive cycles are all accepted, except in the SUBMIT cycle.
- Timeout: last accepted key at cycle N → `timeout_flag` at N+TIMEOUT_CYCLES.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `KEYPAD_BACKSPACE_EN`
  - **Defined:** 0xC in ENTRY does buffer <= {4'h0, buffer[31:4]} and count-- (floor 0). If count reaches 0, state goes to IDLE. The timeout counter is cleared.
  - **Undefined:** 0xC is ignored like 0xA/0xB/0xD, and it does not clear the timeout counter.

## Test plan
- **Eight-digit entry:** digits 1,2,3,4,5,6,7,8 then ENTER → `entered_code`=32'h12345678, `code_valid` one cycle, `digit_count`=0, state IDLE.
- **Short code and empty ENTER:** 9,9 then ENTER → `entered_code`=32'h00000099. ENTER with empty buffer → no `code_valid`, and `entered_code` stays 32'h00000099.
- **Overflow:** digits 1..9 then ENTER → `entered_code`=32'h12345678 (ninth digit dropped). Then 4,CLEAR,ENTER → no pulse.
- **Timeout:** TIMEOUT_CYCLES=16; digit 5, then idle 16 cycles → `timeout_flag` pulse, `digit_count`=0. A key on the expiry cycle is accepted, with no flag.
- **Reset mid-entry:** 7,7 entered, `rst` for 1 cycle, then ENTER → no `code_valid`; `entered_code`=0.
- **Backspace, with `KEYPAD_BACKSPACE_EN`:** 1,2,3,0xC,4,ENTER → 32'h00000124. Without the macro, the same sequence → 32'h00001234.
